// File: rtl/mvau_inp_buf_ctrl.sv
// Input-buffer sequencer for the MVAU stream: writes and passes through the first
// neuron fold, then replays the stored vector from the buffer for the remaining folds.
module mvau_inp_buf_ctrl #(
  parameter int SF       = 16,
  parameter int NF       = 4,
  parameter int BUF_ADDR = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                out_rdy,
  output logic                out_v,
  output logic                wr_en,
  output logic                rd_en,
  output logic [BUF_ADDR-1:0] addr,
  output logic                sf_first,
  output logic                sf_last,
  output logic                vec_done
);

  localparam int NFW = $clog2(NF) + 1;
  localparam logic [BUF_ADDR-1:0] SF_LAST  = BUF_ADDR'(SF - 1);
  localparam logic [BUF_ADDR-1:0] SF_ZERO  = BUF_ADDR'(0);
  localparam logic [BUF_ADDR-1:0] SF_ONE   = BUF_ADDR'(1);
  localparam logic [NFW-1:0]      NF_LAST  = NFW'(NF - 1);
  localparam logic [NFW-1:0]      NF_ZERO  = NFW'(0);
  localparam logic [NFW-1:0]      NF_ONE   = NFW'(1);
  localparam logic                MULTI_NF = (NF > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t              state_r, state_nxt;
  logic [BUF_ADDR-1:0] sf_cnt_r, sf_cnt_nxt;
  logic [NFW-1:0]      nf_cnt_r, nf_cnt_nxt;
  logic                vec_done_r, vec_done_nxt;
  logic                xfer_s;
  logic                sf_wrap_s;
  logic                nf_wrap_s;

  assign sf_wrap_s = (sf_cnt_r == SF_LAST);
  assign nf_wrap_s = (nf_cnt_r == NF_LAST);
  assign vec_done  = vec_done_r;

  // State, fold counters and the completion pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sf_cnt_r   <= SF_ZERO;
      nf_cnt_r   <= NF_ZERO;
      vec_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      sf_cnt_r   <= sf_cnt_nxt;
      nf_cnt_r   <= nf_cnt_nxt;
      vec_done_r <= vec_done_nxt;
    end
  end

  // Handshake/buffer-control decode and next-state logic
  always_comb begin
    state_nxt    = state_r;
    sf_cnt_nxt   = sf_cnt_r;
    nf_cnt_nxt   = nf_cnt_r;
    vec_done_nxt = 1'b0;
    xfer_s       = 1'b0;
    in_rdy       = 1'b0;
    out_v        = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    addr         = SF_ZERO;
    sf_first     = 1'b0;
    sf_last      = 1'b0;

    case (state_r)
      IDLE: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        xfer_s   = in_v & out_rdy;
        in_rdy   = out_rdy;
        out_v    = in_v;
        wr_en    = in_v & out_rdy;
        addr     = sf_cnt_r;
        sf_first = (sf_cnt_r == SF_ZERO);
        sf_last  = sf_wrap_s;
        if (xfer_s && sf_wrap_s) begin
          state_nxt = MULTI_NF ? READ : WRITE;
        end else begin
          state_nxt = WRITE;
        end
      end
      READ: begin
        xfer_s   = out_rdy;
        out_v    = 1'b1;
        rd_en    = 1'b1;
        addr     = sf_cnt_r;
        sf_first = (sf_cnt_r == SF_ZERO);
        sf_last  = sf_wrap_s;
        if (xfer_s && sf_wrap_s && nf_wrap_s) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = READ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A stalled cycle leaves every counter untouched
    if (xfer_s) begin
      if (sf_wrap_s) begin
        sf_cnt_nxt   = SF_ZERO;
        nf_cnt_nxt   = nf_wrap_s ? NF_ZERO : (nf_cnt_r + NF_ONE);
        vec_done_nxt = nf_wrap_s;
      end else begin
        sf_cnt_nxt   = sf_cnt_r + SF_ONE;
        nf_cnt_nxt   = nf_cnt_r;
        vec_done_nxt = 1'b0;
      end
    end else begin
      sf_cnt_nxt   = sf_cnt_r;
      nf_cnt_nxt   = nf_cnt_r;
      vec_done_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Directed bench: table of per-cycle vectors for SF=4/NF=3, plus small
// hand-modelled sequences for the SF=2/NF=1 and SF=1/NF=2 corner configurations.
module tb_mvau_inp_buf_ctrl;

  logic clk;
  logic rst_n;
  logic in_v;
  logic out_rdy;

  logic       ir0, ov0, we0, re0, sff0, sfl0, vd0;
  logic [3:0] ad0;
  logic       ir1, ov1, we1, re1, sff1, sfl1, vd1;
  logic [0:0] ad1;
  logic       ir2, ov2, we2, re2, sff2, sfl2, vd2;
  logic [0:0] ad2;

  int total;
  int passed;

  mvau_inp_buf_ctrl #(.SF(4), .NF(3), .BUF_ADDR(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(ir0), .out_rdy(out_rdy),
    .out_v(ov0), .wr_en(we0), .rd_en(re0), .addr(ad0),
    .sf_first(sff0), .sf_last(sfl0), .vec_done(vd0)
  );

  mvau_inp_buf_ctrl #(.SF(2), .NF(1), .BUF_ADDR(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(ir1), .out_rdy(out_rdy),
    .out_v(ov1), .wr_en(we1), .rd_en(re1), .addr(ad1),
    .sf_first(sff1), .sf_last(sfl1), .vec_done(vd1)
  );

  mvau_inp_buf_ctrl #(.SF(1), .NF(2), .BUF_ADDR(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(ir2), .out_rdy(out_rdy),
    .out_v(ov2), .wr_en(we2), .rd_en(re2), .addr(ad2),
    .sf_first(sff2), .sf_last(sfl2), .vec_done(vd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word layout: {in_rdy,out_v,wr_en,rd_en,addr[3:0],sf_first,sf_last,vec_done}
  typedef struct {
    logic        rst;
    logic        iv;
    logic        ordy;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic iv, input logic ordy,
                     input logic [3:0] flags, input logic [3:0] ad, input logic [2:0] tail);
    vec_t v;
    v.rst  = rst;
    v.iv   = iv;
    v.ordy = ordy;
    v.exp  = {flags, ad, tail};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  initial begin
    logic [10:0] act;
    logic [10:0] exp;
    logic        n1, p1, x, e1, ph, e2;
    total   = 0;
    passed  = 0;
    rst_n   = 1'b0;
    in_v    = 1'b0;
    out_rdy = 1'b0;

    // vector 1: IDLE cycle, 4 writes, 8 replays
    add(1'b1, 1'b1, 1'b1, 4'b0000, 4'd0, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd0, 3'b100);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd1, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd3, 3'b010);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd0, 3'b100);
    add(1'b1, 1'b0, 1'b1, 4'b0101, 4'd1, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd3, 3'b010);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd0, 3'b100);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd1, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd3, 3'b010);
    // vector 2: vec_done pulse, input bubbles, write stall, read backpressure
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd0, 3'b101);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd1, 3'b000);
    add(1'b1, 1'b0, 1'b1, 4'b1000, 4'd2, 3'b000);
    add(1'b1, 1'b0, 1'b1, 4'b1000, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b0, 4'b0100, 4'd3, 3'b010);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd3, 3'b010);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd0, 3'b100);
    add(1'b1, 1'b1, 1'b0, 4'b0101, 4'd1, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd1, 3'b000);
    add(1'b1, 1'b1, 1'b0, 4'b0101, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b0, 4'b0101, 4'd3, 3'b010);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd3, 3'b010);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd0, 3'b100);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd1, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd2, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0101, 4'd3, 3'b010);
    add(1'b1, 1'b0, 1'b1, 4'b1000, 4'd0, 3'b101);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0, 3'b100);
    // mid-vector async reset, one IDLE cycle, restart at sf=0
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd0, 3'b100);
    add(1'b0, 1'b1, 1'b1, 4'b0000, 4'd0, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b0000, 4'd0, 3'b000);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd0, 3'b100);
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'd1, 3'b000);

    repeat (2) @(negedge clk);
    #1;
    check("u0 in reset", {ir0, ov0, we0, re0, ad0, sff0, sfl0, vd0}, 11'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n   = tbl[i].rst;
      in_v    = tbl[i].iv;
      out_rdy = tbl[i].ordy;
      #1;
      act = {ir0, ov0, we0, re0, ad0, sff0, sfl0, vd0};
      check($sformatf("u0 step %0d", i), act, tbl[i].exp);
    end

    // SF=2/NF=1 and SF=1/NF=2 from a fresh reset, with a two-cycle stall
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    in_v    = 1'b1;
    out_rdy = 1'b1;
    #1;
    check("u1 idle", {ir1, ov1, we1, re1, 3'b000, ad1, sff1, sfl1, vd1}, 11'd0);
    check("u2 idle", {ir2, ov2, we2, re2, 3'b000, ad2, sff2, sfl2, vd2}, 11'd0);

    n1 = 1'b0;
    e1 = 1'b0;
    ph = 1'b0;
    e2 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_v    = 1'b1;
      out_rdy = (k != 5) && (k != 6);
      #1;
      exp = {out_rdy, 1'b1, out_rdy, 1'b0, 3'b000, n1, ~n1, n1, e1};
      check($sformatf("u1 cycle %0d", k), {ir1, ov1, we1, re1, 3'b000, ad1, sff1, sfl1, vd1}, exp);
      if (ph) exp = {4'b0101, 4'd0, 2'b11, e2};
      else    exp = {out_rdy, 1'b1, out_rdy, 1'b0, 4'd0, 2'b11, e2};
      check($sformatf("u2 cycle %0d", k), {ir2, ov2, we2, re2, 3'b000, ad2, sff2, sfl2, vd2}, exp);
      x  = out_rdy;
      p1 = n1;
      e1 = x && p1;
      if (x) n1 = ~n1;
      e2 = x && ph;
      if (x) ph = ~ph;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
